// File: rtl/ext_dram_responder_if.sv
// Bus bundle between an ext_dram client, the responder and the sdram back end.
// The slave view belongs to the responder; the master view is the client/back-end side.
interface ext_dram_responder_if #(
    parameter int MEM_ADDR_BITS = 22,
    parameter int XLEN          = 32
);
    logic [MEM_ADDR_BITS-1:0] ext_dram_mem_addr;
    logic                     ext_dram_mem_read_en;
    logic                     ext_dram_mem_write_en;
    logic [XLEN/8-1:0]        ext_dram_mem_byte_enable;
    logic [XLEN-1:0]          ext_dram_mem_write_data;
    logic                     ext_dram_ack;
    logic [XLEN-1:0]          ext_dram_mem_read_data;

    logic [MEM_ADDR_BITS+1:0] sdram_addr;
    logic                     sdram_read;
    logic                     sdram_write;
    logic [XLEN/8-1:0]        sdram_byteenable;
    logic [XLEN-1:0]          sdram_writedata;
    logic                     sdram_waitrequest;
    logic                     sdram_readdatavalid;
    logic [XLEN-1:0]          sdram_readdata;

    modport slave (
        input  ext_dram_mem_addr, ext_dram_mem_read_en, ext_dram_mem_write_en,
        input  ext_dram_mem_byte_enable, ext_dram_mem_write_data,
        output ext_dram_ack, ext_dram_mem_read_data,
        output sdram_addr, sdram_read, sdram_write, sdram_byteenable, sdram_writedata,
        input  sdram_waitrequest, sdram_readdatavalid, sdram_readdata
    );

    modport master (
        output ext_dram_mem_addr, ext_dram_mem_read_en, ext_dram_mem_write_en,
        output ext_dram_mem_byte_enable, ext_dram_mem_write_data,
        input  ext_dram_ack, ext_dram_mem_read_data,
        input  sdram_addr, sdram_read, sdram_write, sdram_byteenable, sdram_writedata,
        output sdram_waitrequest, sdram_readdatavalid, sdram_readdata
    );
endinterface

// File: rtl/ext_dram_responder.sv
// Single-outstanding bridge from the ext_dram word-address request port to an
// sdram-style byte-address back end with waitrequest/readdatavalid handshakes.
//
// state   | meaning
// IDLE    | no transaction; a read or write strobe is captured here
// ISSUE   | command on the back end, held until waitrequest drops
// WAIT_RD | read accepted, waiting for readdatavalid or the timeout
// ACK     | one-cycle completion pulse to the client
module ext_dram_responder #(
    parameter int MEM_ADDR_BITS = 22,
    parameter int XLEN          = 32,
    parameter int RD_TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    ext_dram_responder_if.slave  bus,
    output logic                 busy,
    output logic                 protocol_error
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

    localparam logic [15:0]     TMR_LOAD = 16'(RD_TIMEOUT - 1);
    localparam logic [XLEN-1:0] BAD_DATA = XLEN'(32'hDEADBEEF);

    state_t                   state;
    state_t                   state_nxt;
    logic                     is_write;
    logic [MEM_ADDR_BITS+1:0] addr_q;
    logic [XLEN/8-1:0]        be_q;
    logic [XLEN-1:0]          wdata_q;
    logic [XLEN-1:0]          rdata_q;
    logic [15:0]              rd_timer;
    logic                     tmr_done;
    logic                     any_strobe;
    logic                     both_strobes;
    logic                     ack;
    logic                     cmd_rd;
    logic                     cmd_wr;

    assign any_strobe   = bus.ext_dram_mem_read_en | bus.ext_dram_mem_write_en;
    assign both_strobes = bus.ext_dram_mem_read_en & bus.ext_dram_mem_write_en;
    assign tmr_done     = (rd_timer == 16'd0);

    assign bus.ext_dram_ack           = ack;
    assign bus.ext_dram_mem_read_data = rdata_q;
    assign bus.sdram_addr             = addr_q;
    assign bus.sdram_byteenable       = be_q;
    assign bus.sdram_writedata        = wdata_q;
    assign bus.sdram_read             = cmd_rd;
    assign bus.sdram_write            = cmd_wr;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        ack       = 1'b0;
        cmd_rd    = 1'b0;
        cmd_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (any_strobe) state_nxt = ISSUE;
            end
            ISSUE: begin
                cmd_rd = ~is_write;
                cmd_wr = is_write;
                if (!bus.sdram_waitrequest) state_nxt = is_write ? ACK : WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.sdram_readdatavalid || tmr_done) state_nxt = ACK;
            end
            ACK: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            is_write       <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            rd_timer       <= 16'd0;
            protocol_error <= 1'b0;
        end else begin
            // A colliding read+write resolves to the write.
            if (state == IDLE && any_strobe) begin
                is_write <= bus.ext_dram_mem_write_en;
                addr_q   <= {bus.ext_dram_mem_addr, 2'b00};
                be_q     <= bus.ext_dram_mem_byte_enable;
                wdata_q  <= bus.ext_dram_mem_write_data;
            end

            if (state == ISSUE && !bus.sdram_waitrequest && !is_write) begin
                rd_timer <= TMR_LOAD;
            end else if (state == WAIT_RD && !tmr_done) begin
                rd_timer <= rd_timer - 16'd1;
            end

            if (state == WAIT_RD) begin
                if (bus.sdram_readdatavalid) begin
                    rdata_q <= bus.sdram_readdata;
                end else if (tmr_done) begin
                    rdata_q <= BAD_DATA;
                end
            end

            if ((any_strobe && (state != IDLE || both_strobes)) ||
                (state == WAIT_RD && !bus.sdram_readdatavalid && tmr_done)) begin
                protocol_error <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ext_dram_responder.md
EXT_DRAM_RESPONDER -- requirements
Module: ext_dram_responder

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_BITS, default 22: word-address width of the ext_dram request port.
REQ-002 The block SHALL have parameter XLEN, default 32: data width; byte-enable width is XLEN/8.
REQ-003 The block SHALL have parameter RD_TIMEOUT, default 255: maximum cycles to wait for sdram_readdatavalid, range 1..65535.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sync_reset, input, 1: reset is synchronous and active-high.
REQ-006 The block SHALL have port ext_dram_mem_addr, input, MEM_ADDR_BITS: request word address.
REQ-007 The block SHALL have port ext_dram_mem_read_en, input, 1: single-cycle read request strobe.
REQ-008 The block SHALL have port ext_dram_mem_write_en, input, 1: single-cycle write request strobe.
REQ-009 The block SHALL have port ext_dram_mem_byte_enable, input, XLEN/8: write byte lanes.
REQ-010 The block SHALL have port ext_dram_mem_write_data, input, XLEN: write data.
REQ-011 The block SHALL have port ext_dram_ack, output, 1: single-cycle completion pulse for reads and writes.
REQ-012 The block SHALL have port ext_dram_mem_read_data, output, XLEN: read data, valid when ext_dram_ack is asserted for a read.
REQ-013 The block SHALL have port sdram_addr, output, MEM_ADDR_BITS+2: back-end byte address.
REQ-014 The block SHALL have ports sdram_read and sdram_write, outputs, 1 each: back-end command strobes.
REQ-015 The block SHALL have ports sdram_byteenable (XLEN/8) and sdram_writedata (XLEN), outputs: back-end write lanes and data.
REQ-016 The block SHALL have ports sdram_waitrequest, sdram_readdatavalid (1 each) and sdram_readdata (XLEN), inputs: back-end handshake and return data.
REQ-017 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-018 The block SHALL have port protocol_error, output, 1: sticky error flag.

Function
REQ-019 The block SHALL implement a state machine with states IDLE, ISSUE, WAIT_RD and ACK.
REQ-020 In IDLE, a cycle with a read or write strobe SHALL capture addr, byte_enable, write_data and the direction into registers, then move to ISSUE.
REQ-021 If read_en and write_en are both high in one cycle, the write SHALL be taken, the read dropped, and protocol_error set.
REQ-022 Any strobe arriving while state is not IDLE SHALL be dropped, set protocol_error, and leave the current transaction unaffected.
REQ-023 In ISSUE, the block SHALL drive sdram_read or sdram_write, with sdram_addr = {captured addr, 2'b00} and the captured byteenable/writedata, holding them stable until a cycle with sdram_waitrequest low.
REQ-024 A write accepted in ISSUE (waitrequest low) SHALL go to ACK; a read accepted in ISSUE SHALL go to WAIT_RD; the command strobes SHALL deassert on the next cycle.
REQ-025 In WAIT_RD, on sdram_readdatavalid the block SHALL register sdram_readdata into ext_dram_mem_read_data and go to ACK.
REQ-026 In WAIT_RD, the block SHALL count wait cycles; when the count reaches RD_TIMEOUT without readdatavalid, it SHALL load 32'hDEADBEEF as read data, set protocol_error and go to ACK.
REQ-027 The block SHALL assert ext_dram_ack for exactly one cycle while in ACK, then return to IDLE; a new strobe SHALL be accepted in the IDLE cycle immediately after ACK.
REQ-028 Minimum latency SHALL be: write strobe at cycle N gives ack at N+2, and read strobe at N with readdatavalid at N+2 gives ack at N+3.
REQ-029 The block SHALL hold ext_dram_mem_read_data until the next read completion; a write completion SHALL NOT change it.
REQ-030 The block SHALL ignore sdram_readdatavalid outside WAIT_RD.
REQ-031 The block SHALL clear protocol_error only on reset.

Reset
REQ-032 While sync_reset is high, on each clock edge the block SHALL force: state IDLE; sdram_read, sdram_write, ext_dram_ack, busy and protocol_error 0; ext_dram_mem_read_data, sdram_addr, sdram_byteenable, sdram_writedata and the timeout counter 0.
REQ-033 Reset asserted mid-transaction SHALL abandon that transaction with no ack, and strobes present during reset SHALL be ignored.

Verification
REQ-034 Write test: write addr 0x10, be 4'hF, data 0x12345678, waitrequest low -> sdram_write at N+1 with sdram_addr 0x40, ack at N+2, protocol_error 0.
REQ-035 Read test: read addr 0x3, waitrequest high 3 cycles, readdatavalid with 0xCAFEF00D 2 cycles after accept -> read held stable for 3 cycles, one-cycle ack, read_data 0xCAFEF00D.
REQ-036 Collision test: simultaneous read+write, then a strobe while busy -> only the first write is issued, exactly one ack, protocol_error stuck at 1.
REQ-037 Timeout test: RD_TIMEOUT=8, read with no readdatavalid -> ack 8 cycles after entering WAIT_RD, read_data 0xDEADBEEF, protocol_error 1.
REQ-038 Reset test: sync_reset asserted during WAIT_RD -> next cycle busy 0 and no ack; a late readdatavalid is ignored; a following read completes normally.
